// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end: fetch FSM state encoding,
// reset vector and default halt address.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC1 = 3'd2,
    EXEC2 = 3'd3,
    HALT  = 3'd4
  } cpu_state_e;

  localparam logic [31:0] RESET_VECTOR      = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR = 32'h0000_0000;

  // Instruction fetches are word aligned; the low two PC bits never reach the bus.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cpu_ifetch_if.sv
// Avalon-MM instruction read port between the fetch sequencer (master) and
// instruction memory (slave).
interface cpu_ifetch_if;
  // Handshake: the master raises avm_read with avm_address and holds both
  // stable; the transfer completes on the rising edge where avm_read=1 and
  // avm_waitrequest=0, and avm_readdata is valid in that same cycle.
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address, avm_read, avm_byteenable,
    input  avm_waitrequest, avm_readdata
  );

  modport slave (
    input  avm_address, avm_read, avm_byteenable,
    output avm_waitrequest, avm_readdata
  );
endinterface

// File: rtl/cpu_byteswap.sv
// Combinational 32-bit byte reversal, converting little-endian bus words into
// big-endian instruction words.
module cpu_byteswap (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  assign dout = {din[7:0], din[15:8], din[23:16], din[31:24]};
endmodule

// File: rtl/cpu_ifetch.sv
// Instruction-fetch sequencer: FETCH -> EXEC1 -> EXEC2 with one pc_wen pulse
// per instruction and a sticky HALT on a fetch from the halt address.
// Build option CPU_IFETCH_BYTESWAP_EN byte-reverses the fetched word.
module cpu_ifetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR = DEFAULT_HALT_ADDR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  pc,
  output logic         pc_wen,
  cpu_ifetch_if.master avm,
  input  logic         stall,
  output logic [31:0]  instr,
  output logic         instr_valid,
  output logic         active,
  output cpu_state_e   state_dbg
);

  cpu_state_e  state;
  logic [31:0] fetch_addr;
  logic [31:0] rd_word;
  logic        halt_hit;
  logic        accept;

  assign fetch_addr = word_addr(pc);
  assign halt_hit   = (fetch_addr == HALT_ADDR);

`ifdef CPU_IFETCH_BYTESWAP_EN
  cpu_byteswap u_byteswap (
    .din  (avm.avm_readdata),
    .dout (rd_word)
  );
`else
  assign rd_word = avm.avm_readdata;
`endif

  // Bus controls decode from the async-reset state, so reset drops avm_read at once.
  assign avm.avm_read       = (state == FETCH) && !halt_hit;
  assign avm.avm_address    = avm.avm_read ? fetch_addr : 32'h0;
  assign avm.avm_byteenable = 4'hF;
  assign accept             = avm.avm_read && !avm.avm_waitrequest;
  assign pc_wen             = (state == EXEC2) && !stall;
  assign state_dbg          = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      active      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          active <= 1'b1;
          state  <= FETCH;
        end
        FETCH: begin
          if (halt_hit) begin
            active <= 1'b0;
            state  <= HALT;
          end else if (accept) begin
            instr       <= rd_word;
            instr_valid <= 1'b1;
            state       <= EXEC1;
          end
        end
        EXEC1: state <= EXEC2;
        EXEC2: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ifetch.sv
// Directed bench for cpu_ifetch: reset, fetch timing with waitrequest/stall,
// misaligned PC, reset during a stalled fetch, and halt stickiness.
module tb_cpu_ifetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_wen;
  logic        stall;
  logic [31:0] instr;
  logic        instr_valid;
  logic        active;
  cpu_state_e  state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  cpu_ifetch_if avm_bus ();

  cpu_ifetch dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_wen      (pc_wen),
    .avm         (avm_bus),
    .stall       (stall),
    .instr       (instr),
    .instr_valid (instr_valid),
    .active      (active),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] swap_model(input logic [31:0] rd);
`ifdef CPU_IFETCH_BYTESWAP_EN
    return {rd[7:0], rd[15:8], rd[23:16], rd[31:24]};
`else
    return rd;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver: called just after the edge that enters FETCH; runs one instruction.
  task automatic run_instr(input logic [31:0] pc_v, input logic [31:0] addr_exp,
                           input logic [31:0] rd_v, input int n_wait, input int n_stall);
    int period;
    int wen_cnt;
    int wen_at;
    cpu_state_e exp_st;
    period  = n_wait + n_stall + 3;
    wen_cnt = 0;
    wen_at  = -1;
    exp_q.push_back(swap_model(rd_v));
    pc = pc_v;
    avm_bus.avm_readdata = rd_v;
    for (int c = 0; c < period; c++) begin
      avm_bus.avm_waitrequest = (c < n_wait);
      stall = (c >= n_wait + 2) && (c < n_wait + 2 + n_stall);
      @(negedge clk);
      if (c <= n_wait)          exp_st = FETCH;
      else if (c == n_wait + 1) exp_st = EXEC1;
      else                      exp_st = EXEC2;
      check("state", 32'(state_dbg), 32'(exp_st));
      if (exp_st == FETCH) begin
        check("avm_read_fetch", 32'(avm_bus.avm_read), 32'd1);
        check("avm_address", avm_bus.avm_address, addr_exp);
        check("active_fetch", 32'(active), 32'd1);
      end else begin
        check("avm_read_exec", 32'(avm_bus.avm_read), 32'd0);
        check("instr_valid", 32'(instr_valid), 32'd1);
        check("instr", instr, exp_q[0]);
      end
      if (pc_wen) begin
        wen_cnt++;
        wen_at = c;
      end
      @(posedge clk);
      #1;
    end
    check("pc_wen_count", 32'(wen_cnt), 32'd1);
    check("pc_wen_cycle", 32'(wen_at), 32'(period - 1));
    void'(exp_q.pop_front());
  endtask

  initial begin
    reset = 1'b0;
    pc    = RESET_VECTOR;
    stall = 1'b0;
    avm_bus.avm_waitrequest = 1'b0;
    avm_bus.avm_readdata    = 32'h2408_0005;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_avm_read", 32'(avm_bus.avm_read), 32'd0);
    check("rst_avm_address", avm_bus.avm_address, 32'h0);
    check("rst_byteenable", 32'(avm_bus.avm_byteenable), 32'hF);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_pc_wen", 32'(pc_wen), 32'd0);
    check("rst_active", 32'(active), 32'd0);

    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("idle_state", 32'(state_dbg), 32'(IDLE));
    check("idle_avm_read", 32'(avm_bus.avm_read), 32'd0);
    @(posedge clk);
    #1;

    // basic, waitrequest, stall, misaligned pc
    run_instr(RESET_VECTOR,  32'hBFC0_0000, 32'h2408_0005, 0, 0);
    run_instr(32'hBFC0_0004, 32'hBFC0_0004, 32'h3C01_1234, 4, 0);
    run_instr(32'hBFC0_0008, 32'hBFC0_0008, 32'h8C22_0000, 0, 2);
    run_instr(32'hBFC0_0007, 32'hBFC0_0004, 32'hAABB_CCDD, 0, 0);

    // reset asserted during a waitrequest-stalled fetch
    pc = 32'hBFC0_0010;
    avm_bus.avm_waitrequest = 1'b1;
    @(negedge clk);
    check("pre_rst_avm_read", 32'(avm_bus.avm_read), 32'd1);
    @(posedge clk);
    #1;
    check("pre_rst_state", 32'(state_dbg), 32'(FETCH));
    reset = 1'b0;
    #1;
    check("midrst_avm_read", 32'(avm_bus.avm_read), 32'd0);
    check("midrst_instr", instr, 32'h0);
    check("midrst_state", 32'(state_dbg), 32'(IDLE));
    check("midrst_instr_valid", 32'(instr_valid), 32'd0);
    check("midrst_active", 32'(active), 32'd0);
    @(posedge clk);
    #1;
    pc = 32'hBFC0_0020;
    avm_bus.avm_waitrequest = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rel_idle_state", 32'(state_dbg), 32'(IDLE));
    @(posedge clk);
    #1;
    run_instr(32'hBFC0_0020, 32'hBFC0_0020, 32'h1234_5678, 0, 0);

    // halt on pc == 0, then sticky with stall toggling
    pc = 32'h0;
    avm_bus.avm_readdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("halt_fetch_state", 32'(state_dbg), 32'(FETCH));
    check("halt_fetch_avm_read", 32'(avm_bus.avm_read), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      stall = i[0];
      pc    = 32'(i * 4);
      @(negedge clk);
      check("halt_state", 32'(state_dbg), 32'(HALT));
      check("halt_active", 32'(active), 32'd0);
      check("halt_pc_wen", 32'(pc_wen), 32'd0);
      check("halt_avm_read", 32'(avm_bus.avm_read), 32'd0);
      check("halt_instr", instr, swap_model(32'h1234_5678));
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
